alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: datapath and accumulator width in bits, legal range 4..32.
REQ-002 Parameter FRAC, default 3: fractional bits discarded from the product, legal range 0..WIDTH-1.
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 nReset  input  1  reset; asynchronous and active-low.
REQ-005 Imm  input  WIDTH  signed immediate operand.
REQ-006 RegData  input  WIDTH  register-file read data.
REQ-007 SW  input  WIDTH  switch input.
REQ-008 Func  input  3  opcode, a picomips_pkg opcode value.
REQ-009 WE  input  1  operation request strobe, sampled on the rising edge.
REQ-010 SelSW  input  1  selects SW as operand A; has priority over SelImm.
REQ-011 SelImm  input  1  selects Imm as operand A when SelSW=0; RegData otherwise.
REQ-012 ACC  output  WIDTH  signed accumulator, registered.
REQ-013 Busy  output  1  high while a multiply is in progress.
REQ-014 Done  output  1  one-cycle completion pulse, registered.
REQ-015 Ovf  output  1  overflow flag of the last completed operation, registered.

Function
REQ-016 Operand A and Imm SHALL be sampled on the edge where WE=1 and Busy=0 (edge E0).
REQ-017 OP_ADD, OP_ADDI: ACC SHALL become ACC+A at E0; Ovf SHALL be set on signed overflow.
REQ-018 OP_RTA, OP_LSW: ACC SHALL become A at E0; Ovf SHALL be cleared.
REQ-019 For ADD, ADDI, RTA and LSW, Done SHALL be high for exactly the one cycle after E0, and Busy SHALL stay low.
REQ-020 OP_MULI: the FSM SHALL move IDLE->MUL at E0, and Busy SHALL be high from E0.
REQ-021 The MUL state SHALL run WIDTH sign-magnitude shift-add iterations, one per edge E1..E(WIDTH).
REQ-022 Multiplier operands SHALL be ACC and Imm as captured at E0.
REQ-023 The full 2*WIDTH-bit signed product SHALL be formed; the result SHALL be product bits [FRAC+WIDTH-1:FRAC].
REQ-024 At E(WIDTH), ACC SHALL take the result, Busy SHALL fall, the FSM SHALL return to IDLE, and Done SHALL pulse for the following cycle.
REQ-025 Multiply Ovf SHALL be set when product bits [2*WIDTH-1:FRAC+WIDTH-1] are not all equal.
REQ-026 The multiplier SHALL handle operands of -2^(WIDTH-1) correctly, with no magnitude overflow.
REQ-027 WE while Busy=1 SHALL be ignored, with no queuing and no effect on the multiply in progress.
REQ-028 WE=0 SHALL change no state; ACC and Ovf SHALL hold.
REQ-029 Undefined Func codes with WE=1 SHALL not change ACC or Ovf and SHALL produce no Done.
REQ-030 ACC SHALL not change while in MUL until E(WIDTH).

Reset
REQ-031 nReset low SHALL immediately force ACC=0, Busy=0, Done=0, Ovf=0 and FSM=IDLE, including mid-multiply.
REQ-032 A multiply aborted by reset SHALL never produce Done.
REQ-033 The first operation SHALL be accepted on the first rising edge after nReset deasserts.

Configuration
REQ-034 With macro ALU_SAT_EN defined, an overflowing ADD or MULI result SHALL clamp to +2^(WIDTH-1)-1 or -2^(WIDTH-1) according to the true sign.
REQ-035 Without ALU_SAT_EN, results SHALL wrap or truncate to WIDTH bits.
REQ-036 Ovf behaviour SHALL be identical with and without ALU_SAT_EN.

Structure
REQ-037 Package picomips_pkg SHALL hold the opcode enum (OP_ADD, OP_ADDI, OP_RTA, OP_LSW, OP_MULI) and the FSM state typedef (IDLE, MUL).
REQ-038 The iterative multiplier SHALL be the sub-module alu_seq_mul, parametrised by WIDTH, with start, busy and valid ports and the full product output.
REQ-039 Operand muxing, the FSM, saturation and ACC registers SHALL reside in alu_seq.

Verification (WIDTH=8, FRAC=3)
REQ-040 LSW with SW=16, then MULI with Imm=24 -> Busy high for 8 cycles, then ACC=48, Done one cycle, Ovf=0.
REQ-041 RTA with A=-16, then MULI with Imm=24 -> ACC=-48; ACC=-128 with MULI Imm=8 -> ACC=-128, Ovf=0.
REQ-042 ACC=100, ADD with A=100 -> ACC=-56, Ovf=1 without ALU_SAT_EN; ACC=127, Ovf=1 with it.
REQ-043 ACC=127, MULI with Imm=127 -> ACC=-32, Ovf=1 without ALU_SAT_EN; ACC=127 with it.
REQ-044 Start MULI, pulse WE with ADD at iteration 3 -> ADD ignored, product unchanged, single Done.
REQ-045 Assert nReset at iteration 5 of a MULI -> ACC=0, Busy=0, no Done; the next ADD of 5 yields ACC=5.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared opcode and FSM state definitions for the picoMIPS sequential ALU.
package picomips_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDI = 3'd1,
      OP_RTA  = 3'd2,
      OP_LSW  = 3'd3,
      OP_MULI = 3'd4
   } opcode_t;

   typedef logic [0:0] state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t MUL  = 1'b1;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative sign-magnitude shift-add multiplier: one partial product per clock,
// WIDTH iterations, full 2*WIDTH-bit signed product presented with valid.
module alu_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic                      Clock,
   input  logic                      nReset,
   input  logic                      start,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic                      busy,
   output logic                      valid,
   output logic signed [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand, sum, term, sum_next;
   logic [WIDTH-1:0]   mplier, mag_a, mag_b;
   logic               neg, last;
   logic [CW-1:0]      cnt;

   // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;

   assign term     = mplier[0] ? mcand : '0;
   assign sum_next = sum + term;
   assign last     = (cnt == CW'(WIDTH-1));
   assign valid    = busy & last;
   // The last partial product is folded in combinationally so the caller can
   // register the result on the same edge that ends the iteration.
   assign product  = neg ? -sum_next : sum_next;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         mcand  <= '0;
         mplier <= '0;
         sum    <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         sum    <= '0;
         neg    <= a[WIDTH-1] ^ b[WIDTH-1];
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         sum    <= sum_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (last)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential accumulator ALU with single-cycle add/load and iterative fixed-point
// multiply. Define ALU_SAT_EN to saturate overflowing ADD/MULI results.
module alu_seq
   import picomips_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FRAC  = 3
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic signed [WIDTH-1:0] Imm,
   input  logic signed [WIDTH-1:0] RegData,
   input  logic signed [WIDTH-1:0] SW,
   input  logic [2:0]              Func,
   input  logic                    WE,
   input  logic                    SelSW,
   input  logic                    SelImm,
   output logic signed [WIDTH-1:0] ACC,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Ovf
);

   localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                    state;
   opcode_t                   op;
   logic signed [WIDTH-1:0]   opa, add_sum, add_res, mul_trunc, mul_res;
   logic signed [2*WIDTH-1:0] product;
   logic                      add_ovf, mul_ovf, accept, mul_start, mul_busy, mul_valid;
   logic                      unused_frac;

   assign op = opcode_t'(Func);

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      opa = RegData;
      if (SelSW)
         opa = SW;
      else if (SelImm)
         opa = Imm;
   end

   assign add_sum = ACC + opa;
   assign add_ovf = (ACC[WIDTH-1] == opa[WIDTH-1]) && (add_sum[WIDTH-1] != ACC[WIDTH-1]);

   // Result keeps bits [FRAC+WIDTH-1:FRAC]; everything above must be a sign extension.
   assign mul_trunc   = product[FRAC+WIDTH-1:FRAC];
   assign mul_ovf     = !((&product[2*WIDTH-1:FRAC+WIDTH-1]) || !(|product[2*WIDTH-1:FRAC+WIDTH-1]));
   assign unused_frac = ^product[FRAC:0];

`ifdef ALU_SAT_EN
   assign add_res = add_ovf ? (ACC[WIDTH-1] ? MIN_VAL : MAX_VAL) : add_sum;
   assign mul_res = mul_ovf ? (product[2*WIDTH-1] ? MIN_VAL : MAX_VAL) : mul_trunc;
`else
   assign add_res = add_sum;
   assign mul_res = mul_trunc;
`endif

   assign accept    = WE && (state == IDLE) && !mul_busy;
   assign mul_start = accept && (op == OP_MULI);
   assign Busy      = (state == MUL);

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .Clock   (Clock),
      .nReset  (nReset),
      .start   (mul_start),
      .a       (ACC),
      .b       (Imm),
      .busy    (mul_busy),
      .valid   (mul_valid),
      .product (product)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         ACC   <= '0;
         Ovf   <= 1'b0;
         Done  <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         Done <= 1'b0;
         if (accept) begin
            case (op)
               OP_ADD, OP_ADDI: begin
                  ACC  <= add_res;
                  Ovf  <= add_ovf;
                  Done <= 1'b1;
               end
               OP_RTA, OP_LSW: begin
                  ACC  <= opa;
                  Ovf  <= 1'b0;
                  Done <= 1'b1;
               end
               OP_MULI: state <= MUL;
               default: ;
            endcase
         end else if ((state == MUL) && mul_valid) begin
            ACC   <= mul_res;
            Ovf   <= mul_ovf;
            Done  <= 1'b1;
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8, FRAC=3), with or without ALU_SAT_EN.
module tb_alu_seq;
   import picomips_pkg::*;

`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              Clock, nReset, WE, SelSW, SelImm;
   logic signed [7:0] Imm, RegData, SW, ACC;
   logic [2:0]        Func;
   logic              Busy, Done, Ovf;
   int                errors = 0;
   int                checks = 0;

   alu_seq #(.WIDTH(8), .FRAC(3)) dut (
      .Clock(Clock), .nReset(nReset), .Imm(Imm), .RegData(RegData), .SW(SW),
      .Func(Func), .WE(WE), .SelSW(SelSW), .SelImm(SelImm),
      .ACC(ACC), .Busy(Busy), .Done(Done), .Ovf(Ovf)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // src: 0=RegData, 1=Imm, 2=SW; unselected sources carry a decoy value
   task automatic set_op(input logic [2:0] f, input int src, input logic signed [7:0] v);
      Func    = f;
      SelSW   = (src == 2);
      SelImm  = (src == 1);
      RegData = (src == 0) ? v : 8'sh5A;
      Imm     = (src == 1) ? v : 8'sh5A;
      SW      = (src == 2) ? v : 8'sh5A;
   endtask

   task automatic issue(input logic [2:0] f, input int src, input logic signed [7:0] v);
      @(negedge Clock);
      set_op(f, src, v);
      WE = 1'b1;
      @(negedge Clock);
      WE = 1'b0;
   endtask

   task automatic run_mul(input logic signed [7:0] imm, input logic signed [7:0] exp_acc,
                          input logic exp_ovf, input string name);
      logic signed [7:0] acc0;
      int n, early;
      bit moved;
      acc0 = ACC; n = 0; early = 0; moved = 0;
      issue(OP_MULI, 1, imm);
      while (Busy && n < 20) begin
         if (ACC !== acc0) moved = 1;
         if (Done) early++;
         n++;
         @(negedge Clock);
      end
      checks++; if (n != 8) begin errors++; $display("FAIL %s busy_cycles: got %0d want 8", name, n); end
      checks++; if (moved || early != 0) begin errors++; $display("FAIL %s during_busy: acc_moved=%0d done_pulses=%0d want 0 0", name, moved, early); end
      checks++; if (ACC !== exp_acc) begin errors++; $display("FAIL %s acc: got %0d want %0d", name, ACC, exp_acc); end
      checks++; if (Ovf !== exp_ovf) begin errors++; $display("FAIL %s ovf: got %b want %b", name, Ovf, exp_ovf); end
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1", name, Done); end
      @(negedge Clock);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, Done); end
   endtask

   task automatic test_reset();
      nReset = 1'b1; WE = 1'b0; set_op(OP_ADD, 0, 8'sd0);
      #2 nReset = 1'b0;
      #1;
      checks++; if (ACC !== 8'sd0) begin errors++; $display("FAIL reset_acc: got %0d want 0", ACC); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
      checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", Ovf); end
      repeat (2) @(negedge Clock);
      set_op(OP_LSW, 2, 8'sd7);
      WE = 1'b1; nReset = 1'b1;
      @(negedge Clock);
      WE = 1'b0;
      checks++; if (ACC !== 8'sd7 || Done !== 1'b1) begin errors++; $display("FAIL first_op: got acc=%0d done=%b want 7 1", ACC, Done); end
   endtask

   task automatic test_add();
      @(negedge Clock);
      set_op(OP_RTA, 2, -8'sd3); SelImm = 1'b1; Imm = 8'sd9; WE = 1'b1;
      @(negedge Clock);
      WE = 1'b0;
      checks++; if (ACC !== -8'sd3) begin errors++; $display("FAIL sel_priority: got %0d want -3", ACC); end
      issue(OP_RTA, 0, 8'sd100);
      issue(OP_ADD, 0, 8'sd100);
      checks++; if (ACC !== (SAT ? 8'sd127 : -8'sd56) || Ovf !== 1'b1 || Done !== 1'b1)
         begin errors++; $display("FAIL add_pos_ovf: got acc=%0d ovf=%b done=%b want %0d 1 1", ACC, Ovf, Done, SAT ? 127 : -56); end
      issue(OP_LSW, 1, -8'sd100);
      checks++; if (ACC !== -8'sd100 || Ovf !== 1'b0) begin errors++; $display("FAIL lsw_clears: got acc=%0d ovf=%b want -100 0", ACC, Ovf); end
      issue(OP_ADD, 2, -8'sd100);
      checks++; if (ACC !== (SAT ? -8'sd128 : 8'sd56) || Ovf !== 1'b1)
         begin errors++; $display("FAIL add_neg_ovf: got acc=%0d ovf=%b want %0d 1", ACC, Ovf, SAT ? -128 : 56); end
      issue(OP_ADDI, 1, 8'sd1);
      checks++; if (ACC !== (SAT ? -8'sd127 : 8'sd57) || Ovf !== 1'b0)
         begin errors++; $display("FAIL addi_no_ovf: got acc=%0d ovf=%b want %0d 0", ACC, Ovf, SAT ? -127 : 57); end
   endtask

   task automatic test_mul();
      issue(OP_LSW, 2, 8'sd16);
      checks++; if (ACC !== 8'sd16 || Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL lsw16: got acc=%0d done=%b busy=%b want 16 1 0", ACC, Done, Busy); end
      run_mul(8'sd24, 8'sd48, 1'b0, "mul_16x24");
      issue(OP_RTA, 0, -8'sd16);
      run_mul(8'sd24, -8'sd48, 1'b0, "mul_m16x24");
      issue(OP_RTA, 1, -8'sd128);
      run_mul(8'sd8, -8'sd128, 1'b0, "mul_m128x8");
      run_mul(-8'sd128, SAT ? 8'sd127 : 8'sd0, 1'b1, "mul_m128xm128");
      issue(OP_RTA, 0, 8'sd127);
      run_mul(8'sd127, SAT ? 8'sd127 : -8'sd32, 1'b1, "mul_127x127");
   endtask

   task automatic test_hold();
      logic signed [7:0] exp_acc;
      int dones;
      exp_acc = SAT ? 8'sd127 : -8'sd32;
      dones = 0;
      set_op(OP_ADD, 0, 8'sd11);
      repeat (3) begin @(negedge Clock); if (Done) dones++; end
      for (int f = 5; f < 8; f++) begin
         @(negedge Clock);
         set_op(3'(f), 0, 8'sd11); WE = 1'b1;
         @(negedge Clock);
         WE = 1'b0;
         if (Done) dones++;
      end
      checks++; if (ACC !== exp_acc || Ovf !== 1'b1) begin errors++; $display("FAIL hold_undef: got acc=%0d ovf=%b want %0d 1", ACC, Ovf, exp_acc); end
      checks++; if (dones != 0) begin errors++; $display("FAIL hold_undef_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_busy_we();
      int n, dones;
      issue(OP_RTA, 0, 8'sd10);
      issue(OP_MULI, 1, 8'sd16);
      n = 0; dones = 0;
      while (Busy && n < 20) begin
         if (n == 3) begin set_op(OP_ADD, 0, 8'sd50); WE = 1'b1; end
         else WE = 1'b0;
         if (Done) dones++;
         n++;
         @(negedge Clock);
      end
      WE = 1'b0;
      checks++; if (ACC !== 8'sd20 || n != 8) begin errors++; $display("FAIL busy_we: got acc=%0d cycles=%0d want 20 8", ACC, n); end
      repeat (3) begin if (Done) dones++; @(negedge Clock); end
      checks++; if (dones != 1 || ACC !== 8'sd20) begin errors++; $display("FAIL busy_we_done: got pulses=%0d acc=%0d want 1 20", dones, ACC); end
   endtask

   task automatic test_back_to_back();
      @(negedge Clock);
      set_op(OP_ADD, 0, 8'sd5); WE = 1'b1;
      @(negedge Clock);
      checks++; if (ACC !== 8'sd25 || Done !== 1'b1) begin errors++; $display("FAIL b2b_add: got acc=%0d done=%b want 25 1", ACC, Done); end
      set_op(OP_RTA, 1, 8'sd1);
      @(negedge Clock);
      WE = 1'b0;
      checks++; if (ACC !== 8'sd1 || Done !== 1'b1) begin errors++; $display("FAIL b2b_rta: got acc=%0d done=%b want 1 1", ACC, Done); end
   endtask

   task automatic test_reset_abort();
      int dones;
      issue(OP_RTA, 0, 8'sd7);
      issue(OP_MULI, 1, 8'sd9);
      repeat (4) @(negedge Clock);
      nReset = 1'b0;
      #1;
      checks++; if (ACC !== 8'sd0 || Busy !== 1'b0 || Done !== 1'b0 || Ovf !== 1'b0)
         begin errors++; $display("FAIL abort_state: got acc=%0d busy=%b done=%b ovf=%b want 0 0 0 0", ACC, Busy, Done, Ovf); end
      @(negedge Clock);
      nReset = 1'b1;
      dones = 0;
      repeat (12) begin @(negedge Clock); if (Done || Busy) dones++; end
      checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", dones); end
      issue(OP_ADD, 0, 8'sd5);
      checks++; if (ACC !== 8'sd5 || Done !== 1'b1) begin errors++; $display("FAIL abort_next_add: got acc=%0d done=%b want 5 1", ACC, Done); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_hold();
      test_busy_we();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
